stopwatch_ctrl: RTL

Control FSM for the stopwatch timer datapath. Conditions the raw pause and reset buttons and the adjust and select switches. Converts the divider's tick pulses into single-cycle count, adjust and clear enables, so the counter runs on the one system clock with no gated or muxed clocks. Sits between the clock divider (tick sources) and the minutes/seconds counter plus 7-segment driver.

---
 rtl/stopwatch_ctrl_if.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: tick inputs, raw buttons/switches and the
// registered enables toward the counter and display driver.
// Optional lap hold signals present when STOPWATCH_LAP_EN is defined.
interface stopwatch_ctrl_if;
  logic tick_1hz, tick_2hz;
  logic btn_pause, btn_reset, sw_adj, sw_sel;
  logic cnt_en, adj_sec_en, adj_min_en, cnt_clr;
  logic blink_on, field_sel, running;
`ifdef STOPWATCH_LAP_EN
  logic btn_lap, disp_hold;
`endif

  modport master (
    output tick_1hz, tick_2hz, btn_pause, btn_reset, sw_adj, sw_sel,
`ifdef STOPWATCH_LAP_EN
    output btn_lap, input disp_hold,
`endif
    input  cnt_en, adj_sec_en, adj_min_en, cnt_clr, blink_on, field_sel, running
  );

  modport slave (
    input  tick_1hz, tick_2hz, btn_pause, btn_reset, sw_adj, sw_sel,
`ifdef STOPWATCH_LAP_EN
    input  btn_lap, output disp_hold,
`endif
    output cnt_en, adj_sec_en, adj_min_en, cnt_clr, blink_on, field_sel, running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: input sync, button debounce, STOP/RUN/ADJ FSM and
// single-cycle enables for the counter on the one system clock.
// Optional lap/display-hold feature: define STOPWATCH_LAP_EN.

// One debounced button: the level flips after DB_CYCLES stable mismatches.
module stopwatch_db #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic press
);
  localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] cnt;
  logic            lvl, lvl_q;

  // Count mismatches; flip the debounced level once the count hits LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl;
      if (din == lvl) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        lvl <= ~lvl;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = lvl & ~lvl_q;
endmodule

module stopwatch_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  sw
);
`ifdef STOPWATCH_LAP_EN
  localparam int NBTN = 3;
`else
  localparam int NBTN = 2;
`endif
  localparam int NRAW = NBTN + 2;

  typedef enum logic [1:0] {STOP, RUN, ADJ} state_t;

  // Raw input vector: buttons in the low bits, then adjust and select switches.
  logic [NRAW-1:0] raw, sync0, sync1;
  logic [NBTN-1:0] press;
  logic            pause_p, reset_p, adj_s, sel_s;

  state_t state;
  logic   cnt_en, adj_sec_en, adj_min_en, cnt_clr, blink_on, field_sel, running;

  assign raw[0]      = sw.btn_pause;
  assign raw[1]      = sw.btn_reset;
`ifdef STOPWATCH_LAP_EN
  assign raw[2]      = sw.btn_lap;
`endif
  assign raw[NBTN]   = sw.sw_adj;
  assign raw[NBTN+1] = sw.sw_sel;

  // Two-flop synchronizer on every asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    stopwatch_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
      .clk   (clk),
      .rst   (rst),
      .din   (sync1[i]),
      .press (press[i])
    );
  end

  assign pause_p = press[0];
  assign reset_p = press[1];
  assign adj_s   = sync1[NBTN];
  assign sel_s   = sync1[NBTN+1];

  // FSM plus registered outputs; enables look at the current (old) state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STOP;
      cnt_en     <= 1'b0;
      adj_sec_en <= 1'b0;
      adj_min_en <= 1'b0;
      cnt_clr    <= 1'b0;
      blink_on   <= 1'b1;
      field_sel  <= 1'b0;
      running    <= 1'b0;
    end else begin
      cnt_en     <= (state == RUN) & sw.tick_1hz & ~reset_p;
      adj_sec_en <= (state == ADJ) & sw.tick_2hz & ~sel_s & ~reset_p;
      adj_min_en <= (state == ADJ) & sw.tick_2hz &  sel_s & ~reset_p;
      cnt_clr    <= reset_p;
      field_sel  <= sel_s;
      // Held high outside ADJ, so it always enters ADJ as 1.
      blink_on   <= (state != ADJ) | (sw.tick_2hz ? ~blink_on : blink_on);
      if (reset_p) begin
        state   <= STOP;
        running <= 1'b0;
      end else if (adj_s) begin
        state   <= ADJ;
        running <= 1'b0;
      end else if (state == ADJ) begin
        state   <= STOP;
        running <= 1'b0;
      end else if (pause_p) begin
        state   <= (state == RUN) ? STOP : RUN;
        running <= (state != RUN);
      end
    end
  end

  assign sw.cnt_en     = cnt_en;
  assign sw.adj_sec_en = adj_sec_en;
  assign sw.adj_min_en = adj_min_en;
  assign sw.cnt_clr    = cnt_clr;
  assign sw.blink_on   = blink_on;
  assign sw.field_sel  = field_sel;
  assign sw.running    = running;

`ifdef STOPWATCH_LAP_EN
  logic disp_hold;

  // Lap toggles the display freeze; a clear or ADJ entry drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           disp_hold <= 1'b0;
    else if (reset_p | adj_s)          disp_hold <= 1'b0;
    else if (press[2] & (state != ADJ)) disp_hold <= ~disp_hold;
  end

  assign sw.disp_hold = disp_hold;
`endif
endmodule
